axi4_lite_dma_master: RTL and testbench

AXI4_LITE_DMA_MASTER -- requirements
Module: axi4_lite_dma_master

---
 rtl/axi4_lite_dma_master_pkg.sv | 25 ++
 rtl/axi4_lite_dma_master_if.sv | 50 +++++
 rtl/axi4_lite_dma_master.sv | 221 ++++++++++++++++++++++
 tb/tb_axi4_lite_dma_master.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_dma_master_pkg.sv
// ---------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the AXI4-Lite single-word DMA copy engine:
//   - dma_state_e : copy FSM state encoding
//   - RESP_OKAY   : AXI OKAY response code
//   - resp_ok()   : true when a response code is OKAY
// ---------------------------------------------------------------------------
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR      = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_DONE    = 3'd5
    } dma_state_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    function automatic logic resp_ok(input logic [1:0] resp);
        return (resp == RESP_OKAY);
    endfunction

endpackage

// File: rtl/axi4_lite_dma_master_if.sv
// ---------------------------------------------------------------------------
// axi4_lite_dma_master_if
// AXI4-Lite bus bundle between the DMA master and a memory slave.
//   Write address : AWADDR, AWVALID, AWREADY
//   Write data    : WDATA, WSTRB, WVALID, WREADY
//   Write resp    : BRESP, BVALID, BREADY
//   Read address  : ARADDR, ARVALID, ARREADY
//   Read data     : RDATA, RRESP, RVALID, RREADY
// Addresses are word indices (ADDR_WIDTH bits), not byte addresses.
// Modports: master (DMA side), slave (memory side).
// ---------------------------------------------------------------------------
interface axi4_lite_dma_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0]     AWADDR;
    logic                      AWVALID;
    logic                      AWREADY;
    logic [DATA_WIDTH-1:0]     WDATA;
    logic [DATA_WIDTH/8-1:0]   WSTRB;
    logic                      WVALID;
    logic                      WREADY;
    logic [1:0]                BRESP;
    logic                      BVALID;
    logic                      BREADY;
    logic [ADDR_WIDTH-1:0]     ARADDR;
    logic                      ARVALID;
    logic                      ARREADY;
    logic [DATA_WIDTH-1:0]     RDATA;
    logic [1:0]                RRESP;
    logic                      RVALID;
    logic                      RREADY;

    modport master (
        output AWADDR, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input  BRESP, BVALID, output BREADY,
        output ARADDR, ARVALID, input ARREADY,
        input  RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input  AWADDR, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input  ARADDR, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );

endinterface

// File: rtl/axi4_lite_dma_master.sv
// ---------------------------------------------------------------------------
// axi4_lite_dma_master
// Copies `length` words from src_addr.. to dst_addr.. over AXI4-Lite, one
// word at a time: read address, read data, write (AW+W), write response.
// Indices wrap modulo 2^ADDR_WIDTH.
// Ports:
//   ACLK, ARESET        clock, asynchronous active-high reset
//   start               request a copy (sampled only in IDLE)
//   src_addr, dst_addr  first source / destination word index
//   length              number of words (0 = immediate done, no bus traffic)
//   busy, done, error   status: not idle / one-cycle end pulse / sticky error
//   m_axi               AXI4-Lite master port
// Build option: define DMA_RESP_CHECK_EN to abort a copy on a non-OKAY
// RRESP/BRESP and raise error; otherwise responses are ignored and error
// stays 0.
// ---------------------------------------------------------------------------
module axi4_lite_dma_master
    import dma_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    axi4_lite_dma_master_if.master m_axi
);

    localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    dma_state_e              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   src_q, src_d;
    logic [ADDR_WIDTH-1:0]   dst_q, dst_d;
    logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   buf_q, buf_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    // AW and W complete independently; each stays pending until its own handshake.
    logic aw_pend_s, w_pend_s;
    assign aw_pend_s = awvalid_q & ~m_axi.AWREADY;
    assign w_pend_s  = wvalid_q  & ~m_axi.WREADY;

`ifdef DMA_RESP_CHECK_EN
    logic rresp_bad_s, bresp_bad_s;
    assign rresp_bad_s = ~resp_ok(m_axi.RRESP);
    assign bresp_bad_s = ~resp_ok(m_axi.BRESP);
`else
    logic unused_resp_s;
    assign unused_resp_s = ^{m_axi.RRESP, m_axi.BRESP};
`endif

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        error_d   = error_q;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length != CNT_ZERO) begin
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        cnt_d   = length;
                        error_d = 1'b0;
                        state_d = ST_RD_ADDR;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            // ARVALID is always high in this state, so ARREADY alone is the handshake.
            ST_RD_ADDR: begin
                if (m_axi.ARREADY) begin
                    state_d = ST_RD_DATA;
                end else begin
                    state_d = ST_RD_ADDR;
                end
            end
            ST_RD_DATA: begin
                if (m_axi.RVALID) begin
`ifdef DMA_RESP_CHECK_EN
                    if (rresp_bad_s) begin
                        error_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        buf_d     = m_axi.RDATA;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WR;
                    end
`else
                    buf_d     = m_axi.RDATA;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = ST_WR;
`endif
                end else begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_WR: begin
                awvalid_d = aw_pend_s;
                wvalid_d  = w_pend_s;
                if (!aw_pend_s && !w_pend_s) begin
                    state_d = ST_WR_RESP;
                end else begin
                    state_d = ST_WR;
                end
            end
            ST_WR_RESP: begin
                if (m_axi.BVALID) begin
                    src_d = src_q + IDX_ONE;
                    dst_d = dst_q + IDX_ONE;
                    cnt_d = cnt_q - CNT_ONE;
`ifdef DMA_RESP_CHECK_EN
                    if (bresp_bad_s) begin
                        error_d = 1'b1;
                        state_d = ST_DONE;
                    end else if (cnt_q == CNT_ONE) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RD_ADDR;
                    end
`else
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RD_ADDR;
                    end
`endif
                end else begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Single-state strobes are decoded from the next state so they register with it.
        arvalid_d = (state_d == ST_RD_ADDR);
        rready_d  = (state_d == ST_RD_DATA);
        bready_d  = (state_d == ST_WR_RESP);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
    end

    // State and datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= ST_IDLE;
            src_q     <= {ADDR_WIDTH{1'b0}};
            dst_q     <= {ADDR_WIDTH{1'b0}};
            cnt_q     <= {(ADDR_WIDTH+1){1'b0}};
            buf_q     <= {DATA_WIDTH{1'b0}};
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    // Address and data outputs come straight from the index/buffer registers.
    assign m_axi.ARADDR  = src_q;
    assign m_axi.ARVALID = arvalid_q;
    assign m_axi.RREADY  = rready_q;
    assign m_axi.AWADDR  = dst_q;
    assign m_axi.AWVALID = awvalid_q;
    assign m_axi.WDATA   = buf_q;
    assign m_axi.WSTRB   = {(DATA_WIDTH/8){1'b1}};
    assign m_axi.WVALID  = wvalid_q;
    assign m_axi.BREADY  = bready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_axi4_lite_dma_master.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_dma_master
// Drives copies into axi4_lite_dma_master against a behavioural AXI4-Lite
// memory slave. A word-level copy model predicts the read address, write
// address and write data sequences plus final memory contents; a compare
// process checks every handshake and bus-protocol rule each cycle.
// Latency convention: done rises 4*length clock edges after the edge that
// accepts start (length 0: done in the cycle right after start).
// ---------------------------------------------------------------------------
module tb_axi4_lite_dma_master;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic          start;
    logic [AW-1:0] src_addr, dst_addr;
    logic [AW:0]   length;
    logic          busy, done, error;

    axi4_lite_dma_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    axi4_lite_dma_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .busy(busy), .done(done), .error(error), .m_axi(bus)
    );

    always #5 ACLK = ~ACLK;

    logic [DW-1:0] mem       [0:1023];
    logic [DW-1:0] model_mem [0:1023];
    logic [AW-1:0] exp_ar[$], exp_aw[$], ar_log[$], aw_log[$];
    logic [DW-1:0] exp_wd[$];
    int tests = 0, fails = 0;
    int mode = 0;            // 0 zero-wait, 1 random, 2 AW early, 3 stall W/AW
    int bresp_err_word = 0;  // 1-based write index answered with SLVERR (0 = none)
    int slv_wcount = 0;
    int ar_cnt, aw_cnt, w_cnt, done_cnt, arv_cyc, awv_cyc, split_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory slave: readies chosen at negedge, responses applied just after posedge.
    initial begin : slave
        logic ar_hs, r_hs, aw_hs, w_hs, b_hs, r_wait, aw_got, w_got, b_wait;
        logic [AW-1:0] ar_a, r_a, aw_a, aw_hold;
        logic [DW-1:0] w_d, w_hold;
        logic [1:0] b_resp;
        int r_pend, b_pend, wwait;
        r_wait = 1'b0; aw_got = 1'b0; w_got = 1'b0; b_wait = 1'b0; wwait = 0;
        r_pend = 0; b_pend = 0; b_resp = 2'b00; aw_hold = '0; w_hold = '0; r_a = '0;
        bus.ARREADY = 1'b0; bus.AWREADY = 1'b0; bus.WREADY = 1'b0;
        bus.RVALID = 1'b0; bus.RDATA = '0; bus.RRESP = 2'b00;
        bus.BVALID = 1'b0; bus.BRESP = 2'b00;
        forever begin
            @(negedge ACLK);
            case (mode)
                0: begin bus.ARREADY = 1'b1; bus.AWREADY = 1'b1; bus.WREADY = 1'b1; end
                1: begin
                    bus.ARREADY = 1'($urandom_range(1, 0));
                    bus.AWREADY = 1'($urandom_range(1, 0));
                    bus.WREADY  = 1'($urandom_range(1, 0));
                end
                2: begin
                    bus.ARREADY = 1'b1; bus.AWREADY = 1'b1;
                    bus.WREADY  = bus.WVALID && (wwait >= 3);
                    if (bus.WVALID && !bus.WREADY) wwait++; else wwait = 0;
                end
                default: begin bus.ARREADY = 1'b1; bus.AWREADY = 1'b0; bus.WREADY = 1'b0; end
            endcase
            ar_hs = bus.ARVALID && bus.ARREADY; ar_a = bus.ARADDR;
            r_hs  = bus.RVALID && bus.RREADY;
            aw_hs = bus.AWVALID && bus.AWREADY; aw_a = bus.AWADDR;
            w_hs  = bus.WVALID && bus.WREADY;   w_d = bus.WDATA;
            b_hs  = bus.BVALID && bus.BREADY;
            @(posedge ACLK); #1;
            if (ARESET) begin
                bus.RVALID = 1'b0; bus.BVALID = 1'b0; r_wait = 1'b0; b_wait = 1'b0;
                aw_got = 1'b0; w_got = 1'b0; wwait = 0;
            end else begin
                if (r_hs) bus.RVALID = 1'b0;
                if (b_hs) bus.BVALID = 1'b0;
                if (ar_hs) begin
                    r_wait = 1'b1; r_a = ar_a;
                    r_pend = (mode == 1) ? $urandom_range(2, 0) : 0;
                end
                if (r_wait) begin
                    if (r_pend == 0) begin
                        bus.RVALID = 1'b1; bus.RDATA = mem[r_a]; bus.RRESP = 2'b00; r_wait = 1'b0;
                    end else r_pend--;
                end
                if (aw_hs) begin aw_got = 1'b1; aw_hold = aw_a; end
                if (w_hs)  begin w_got = 1'b1;  w_hold = w_d;  end
                if (aw_got && w_got) begin
                    mem[aw_hold] = w_hold; aw_got = 1'b0; w_got = 1'b0;
                    slv_wcount++;
                    b_resp = (slv_wcount == bresp_err_word) ? 2'b10 : 2'b00;
                    b_wait = 1'b1;
                    b_pend = (mode == 1) ? $urandom_range(2, 0) : 0;
                end
                if (b_wait) begin
                    if (b_pend == 0) begin
                        bus.BVALID = 1'b1; bus.BRESP = b_resp; b_wait = 1'b0;
                    end else b_pend--;
                end
            end
        end
    end

    // Per-cycle protocol and data checks against the copy model's queues.
    initial begin : compare
        logic p_ar, p_aw, p_w;
        logic [AW-1:0] p_ara, p_awa;
        logic [DW-1:0] p_wd;
        p_ar = 1'b0; p_aw = 1'b0; p_w = 1'b0; p_ara = '0; p_awa = '0; p_wd = '0;
        forever begin
            @(negedge ACLK); #2;
            if (ARESET) begin
                p_ar = 1'b0; p_aw = 1'b0; p_w = 1'b0;
            end else begin
                if (p_ar) check("ar_hold", {bus.ARVALID, bus.ARADDR}, {1'b1, p_ara});
                if (p_aw) check("aw_hold", {bus.AWVALID, bus.AWADDR}, {1'b1, p_awa});
                if (p_w)  check("w_hold",  {bus.WVALID, bus.WDATA},  {1'b1, p_wd});
                if (bus.ARVALID || bus.RREADY || bus.AWVALID || bus.WVALID || bus.BREADY) begin
                    check("no_overlap", (bus.ARVALID || bus.RREADY) && (bus.AWVALID || bus.WVALID || bus.BREADY), 1'b0);
                    check("busy_with_bus", busy, 1'b1);
                end
                if (bus.ARVALID) arv_cyc++;
                if (bus.AWVALID) awv_cyc++;
                if (!bus.AWVALID && bus.WVALID) split_cnt++;
                if (bus.ARVALID && bus.ARREADY) begin
                    ar_cnt++; ar_log.push_back(bus.ARADDR);
                    check("ar_expected", exp_ar.size() > 0, 1'b1);
                    if (exp_ar.size() > 0) check("araddr", bus.ARADDR, exp_ar.pop_front());
                end
                if (bus.AWVALID && bus.AWREADY) begin
                    aw_cnt++; aw_log.push_back(bus.AWADDR);
                    check("aw_expected", exp_aw.size() > 0, 1'b1);
                    if (exp_aw.size() > 0) check("awaddr", bus.AWADDR, exp_aw.pop_front());
                end
                if (bus.WVALID && bus.WREADY) begin
                    w_cnt++;
                    check("wstrb", bus.WSTRB, 4'hF);
                    check("w_expected", exp_wd.size() > 0, 1'b1);
                    if (exp_wd.size() > 0) check("wdata", bus.WDATA, exp_wd.pop_front());
                end
                if (done) done_cnt++;
`ifndef DMA_RESP_CHECK_EN
                check("error_tied", error, 1'b0);
`endif
                p_ar = bus.ARVALID && !bus.ARREADY; p_ara = bus.ARADDR;
                p_aw = bus.AWVALID && !bus.AWREADY; p_awa = bus.AWADDR;
                p_w  = bus.WVALID && !bus.WREADY;   p_wd = bus.WDATA;
            end
        end
    end

    // One copy: build model expectations, start, wait for done, check results.
    task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n,
                            input int words, input bit noise, output int lat);
        logic [AW-1:0] a, b;
        int budget;
        exp_ar.delete(); exp_aw.delete(); exp_wd.delete(); ar_log.delete(); aw_log.delete();
        for (int i = 0; i < n; i++) begin
            a = s + AW'(i); b = d + AW'(i);
            exp_ar.push_back(a); exp_aw.push_back(b); exp_wd.push_back(model_mem[a]);
            if (i < words) model_mem[b] = model_mem[a];
        end
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; done_cnt = 0; arv_cyc = 0; awv_cyc = 0;
        split_cnt = 0; slv_wcount = 0;
        budget = 40 * n + 10;
        @(negedge ACLK);
        start = 1'b1; src_addr = s; dst_addr = d; length = (AW+1)'(n);
        @(posedge ACLK); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        lat = 0;
        while (!done && lat < budget) begin
            @(posedge ACLK); #1;
            lat++;
            if (noise && !done) begin
                start = 1'($urandom_range(1, 0));
                src_addr = AW'($urandom); dst_addr = AW'($urandom);
                length = (AW+1)'($urandom_range(5, 1));
            end
        end
        start = 1'b0;
        check("done_seen", done, 1'b1);
        @(posedge ACLK); #1;
        check("done_one_cycle", done, 1'b0);
        check("idle_not_busy", busy, 1'b0);
        check("ar_count", ar_cnt, words);
        check("aw_count", aw_cnt, words);
        check("w_count", w_cnt, words);
        check("done_pulses", done_cnt, 1);
        for (int i = 0; i < n; i++) begin
            b = d + AW'(i);
            check("mem_dst", mem[b], model_mem[b]);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int lat, k, n;
        logic [AW-1:0] s, d;
        ARESET = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom; model_mem[i] = mem[i];
        end
        #12;
        check("rst_arvalid", bus.ARVALID, 1'b0); check("rst_awvalid", bus.AWVALID, 1'b0);
        check("rst_wvalid", bus.WVALID, 1'b0);   check("rst_rready", bus.RREADY, 1'b0);
        check("rst_bready", bus.BREADY, 1'b0);   check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);           check("rst_error", error, 1'b0);
        check("rst_addrs", {bus.ARADDR, bus.AWADDR, bus.WDATA}, 64'd0);
        @(negedge ACLK); ARESET = 1'b0;

        // Four-word copy with hand-computed expectations.
        for (int i = 0; i < 4; i++) begin
            mem[10'h010 + i] = 32'hA0 + i; model_mem[10'h010 + i] = 32'hA0 + i;
        end
        mode = 0;
        run_copy(10'h010, 10'h100, 4, 4, 1'b0, lat);
        check("lat_4_words", lat, 16);
        for (int i = 0; i < 4; i++) check("copy_literal", mem[10'h100 + i], 32'hA0 + i);
        check("error_after_copy", error, 1'b0);

        // Zero length: done immediately, no bus activity.
        run_copy(10'h005, 10'h200, 0, 0, 1'b0, lat);
        check("lat_len0", lat, 0);
        check("len0_no_arvalid", arv_cyc, 0);
        check("len0_no_awvalid", awv_cyc, 0);

        // Index wrap at the top of the address space.
        run_copy(10'h3FE, 10'h3FF, 3, 3, 1'b0, lat);
        check("wrap_ar_n", ar_log.size(), 3);
        check("wrap_aw_n", aw_log.size(), 3);
        if (ar_log.size() == 3 && aw_log.size() == 3) begin
            check("wrap_ar0", ar_log[0], 10'h3FE); check("wrap_ar1", ar_log[1], 10'h3FF);
            check("wrap_ar2", ar_log[2], 10'h000);
            check("wrap_aw0", aw_log[0], 10'h3FF); check("wrap_aw1", aw_log[1], 10'h000);
            check("wrap_aw2", aw_log[2], 10'h001);
        end

        // AWREADY three cycles ahead of WREADY.
        mode = 2;
        run_copy(10'h020, 10'h040, 3, 3, 1'b0, lat);
        check("w_held_after_aw", split_cnt, 9);

        // Reset while in WR, then a clean single-word copy.
        mode = 3;
        exp_ar.delete(); exp_aw.delete(); exp_wd.delete();
        exp_ar.push_back(10'h070);
        @(negedge ACLK);
        start = 1'b1; src_addr = 10'h070; dst_addr = 10'h078; length = 11'd2;
        @(posedge ACLK); #1;
        start = 1'b0;
        k = 0;
        while (!bus.AWVALID && k < 20) begin @(posedge ACLK); #1; k++; end
        check("reached_wr", {bus.AWVALID, bus.WVALID}, 2'b11);
        #1 ARESET = 1'b1;
        #1;
        check("rst_mid_valids", {bus.ARVALID, bus.RREADY, bus.AWVALID, bus.WVALID, bus.BREADY}, 5'b0);
        check("rst_mid_status", {busy, done, error}, 3'b0);
        check("rst_mid_data", {bus.AWADDR, bus.WDATA}, 64'd0);
        @(negedge ACLK); @(negedge ACLK);
        ARESET = 1'b0;
        check("no_write_after_rst", mem[10'h078], model_mem[10'h078]);
        mode = 0;
        run_copy(10'h070, 10'h078, 1, 1, 1'b0, lat);
        check("lat_after_rst", lat, 4);

        // SLVERR on the second write of four.
        bresp_err_word = 2;
`ifdef DMA_RESP_CHECK_EN
        run_copy(10'h080, 10'h090, 4, 2, 1'b0, lat);
        check("bresp_error_set", error, 1'b1);
        bresp_err_word = 0;
        run_copy(10'h0A0, 10'h0B0, 1, 1, 1'b0, lat);
        check("error_cleared", error, 1'b0);
`else
        run_copy(10'h080, 10'h090, 4, 4, 1'b0, lat);
        check("bresp_ignored", error, 1'b0);
        bresp_err_word = 0;
`endif

        // Randomised copies with random slave timing and start noise while busy.
        for (int t = 0; t < 12; t++) begin
            mode = $urandom_range(1, 0);
            s = AW'($urandom); d = AW'($urandom);
            n = $urandom_range(5, 1);
            run_copy(s, d, n, n, 1'b1, lat);
            if (mode == 0) check("lat_zero_wait", lat, 4 * n);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
